mul32_seq_yjy: RTL

Sequential unsigned 32×32→64 multiplier built around one `mul8_yjy` 8×8 Booth core.
- Sits directly downstream of the core and consumes its two 16-bit carry-save vectors.
- Also drives the core's operands: one byte pair per cycle over 16 steps.
- Resolves each byte product, shifts it into position and accumulates it into a 64-bit result.
- Valid/ready handshakes on both sides; one operation in flight at a time.

---
 rtl/mul32_seq_yjy_pkg.sv | 22 ++
 rtl/mul8_yjy.sv | 56 +++++
 rtl/mul32_seq_yjy.sv | 117 +++++++++++
 3 files changed

// File: rtl/mul32_seq_yjy_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// Combinational helper only; no latency, no flow control.
package mul32_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int STEPS  = 16;
   localparam int BYTE_W = 8;
   localparam int PROD_W = 64;
   localparam int PP_W   = 2 * BYTE_W;

   // Bit offset of the byte product for step k: 8 * (k[1:0] + k[3:2]).
   function automatic logic [5:0] byte_shift(input logic [3:0] step);
      logic [2:0] sum;
      sum = {1'b0, step[1:0]} + {1'b0, step[3:2]};
      return {sum, 3'b000};
   endfunction
endpackage

// File: rtl/mul8_yjy.sv
// Unsigned 8x8 radix-4 Booth core; five partial products reduced to two carry-save vectors.
// Purely combinational (sum of outputs mod 2^16 = a*b); no flow control.
module mul8_yjy #(
   parameter int    UUID = 0,
   parameter string NAME = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  wi_a_8bit,
   input  logic [7:0]  wi_b_8bit,
   output logic [15:0] wo_compr0_16bit,
   output logic [15:0] wo_compr1_16bit
);
   function automatic logic [15:0] booth_pp(input logic [7:0] a, input logic [2:0] t);
      logic [15:0] m;
      m = {8'b0, a};
      case (t)
         3'b001, 3'b010: return m;
         3'b011:         return m << 1;
         3'b100:         return -(m << 1);
         3'b101, 3'b110: return -m;
         default:        return '0;
      endcase
   endfunction

   function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
      logic [15:0] s;
      logic [15:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   // Two zero bits above b keep the unsigned multiplier positive; one below seeds digit 0.
   logic [10:0] be;
   logic [15:0] pp [5];
   logic [31:0] r1, r2, r3;

   assign be = {2'b00, wi_b_8bit, 1'b0};

   for (genvar gi = 0; gi < 5; gi++) begin : g_pp
      assign pp[gi] = booth_pp(wi_a_8bit, be[2*gi +: 3]) << (2 * gi);
   end

   assign r1 = csa(pp[0], pp[1], pp[2]);
   assign r2 = csa(r1[15:0], r1[31:16], pp[3]);
   assign r3 = csa(r2[15:0], r2[31:16], pp[4]);

   assign wo_compr0_16bit = r3[15:0];
   assign wo_compr1_16bit = r3[31:16];

   a_exact: assert property (@(posedge clk) disable iff (rst)
      16'(wo_compr0_16bit + wo_compr1_16bit) == 16'({8'b0, wi_a_8bit} * {8'b0, wi_b_8bit}))
      else $error("%s uuid=%0d: carry-save pair does not sum to the byte product", NAME, UUID);
endmodule

// File: rtl/mul32_seq_yjy.sv
// Sequential unsigned 32x32->64 multiplier, one byte pair per cycle through mul8_yjy.
// 18 cycles accept-to-valid; one op in flight, result held in DONE until wi_ready.
module mul32_seq_yjy
   import mul32_pkg::*;
#(
   parameter int    UUID = 0,
   parameter string NAME = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wi_valid,
   output logic        wo_ready,
   input  logic [31:0] wi_a_32bit,
   input  logic [31:0] wi_b_32bit,
   output logic        wo_valid,
   input  logic        wi_ready,
   output logic [63:0] wo_prod_64bit,
   output logic        wo_busy
);
   state_t              state_q;
   logic [31:0]         a_q, b_q;
   logic [PROD_W-1:0]   acc_q;
   logic [PP_W-1:0]     pp_q;
   logic [5:0]          sh_q;
   logic                pp_vld_q;
   logic [3:0]          step_q;
   logic                ready_q, valid_q, busy_q;

   logic [BYTE_W-1:0]   byte_a, byte_b;
   logic [PP_W-1:0]     compr0, compr1, byte_prod;
   logic [PROD_W-1:0]   pp_shift;

   assign byte_a    = a_q[{step_q[1:0], 3'b000} +: BYTE_W];
   assign byte_b    = b_q[{step_q[3:2], 3'b000} +: BYTE_W];
   assign byte_prod = compr0 + compr1;
   assign pp_shift  = {{(PROD_W-PP_W){1'b0}}, pp_q} << sh_q;

   mul8_yjy #(
      .UUID (UUID ^ 32'h0000_5A5A),
      .NAME (NAME)
   ) u_mul8 (
      .clk             (clk),
      .rst             (rst),
      .wi_a_8bit       (byte_a),
      .wi_b_8bit       (byte_b),
      .wo_compr0_16bit (compr0),
      .wo_compr1_16bit (compr1)
   );

   // Byte product from step k is added during step k+1 (or DRAIN for the last one).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         pp_q     <= '0;
         sh_q     <= '0;
         pp_vld_q <= 1'b0;
         step_q   <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wi_valid) begin
                  a_q      <= wi_a_32bit;
                  b_q      <= wi_b_32bit;
                  acc_q    <= '0;
                  step_q   <= '0;
                  pp_vld_q <= 1'b0;
                  state_q  <= RUN;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            RUN: begin
               pp_q     <= byte_prod;
               sh_q     <= byte_shift(step_q);
               pp_vld_q <= 1'b1;
               if (pp_vld_q)
                  acc_q <= acc_q + pp_shift;
               step_q <= step_q + 4'd1;
               if (step_q == 4'(STEPS - 1))
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (pp_vld_q)
                  acc_q <= acc_q + pp_shift;
               pp_vld_q <= 1'b0;
               state_q  <= DONE;
               busy_q   <= 1'b0;
               valid_q  <= 1'b1;
            end
            DONE: begin
               if (wi_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wo_ready      = ready_q;
   assign wo_valid      = valid_q;
   assign wo_busy       = busy_q;
   assign wo_prod_64bit = acc_q;
endmodule
